estoque_rolhas: RTL and testbench

Cork-stock and production-count controller sitting beside the bottling FSM. It drives that FSM's `RO` input (corks available) and consumes its `GP` output (bottle produced). Each produced bottle uses one cork and adds to the box count. When the stock runs low, the block requests a refill from the cork feeder over a valid/ready handshake.

---
 rtl/estoque_rolhas.sv | 138 +++++++++++++
 tb/tb_estoque_rolhas.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/estoque_rolhas.sv
// Cork-stock and production-count controller beside the bottling FSM.
// Tracks cork stock, requests refills from the feeder and counts bottles/boxes.
module estoque_rolhas #(
  parameter int unsigned CAPACITY   = 20,
  parameter int unsigned LOW_THRESH = 5,
  parameter int unsigned W          = 5,
  parameter int unsigned BOX_SIZE   = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         GP,
  input  logic         add_valid,
  output logic         add_ready,
  output logic         RO,
  output logic         req_abast,
  output logic [W-1:0] estoque,
  output logic [1:0]   estado,
  output logic [15:0]  total_garrafas,
  output logic         caixa_pronta,
  output logic         erro_consumo
);

  localparam int unsigned BW = (BOX_SIZE > 1) ? $clog2(BOX_SIZE) : 1;
  localparam logic [W-1:0]  CapW    = W'(CAPACITY);
  localparam logic [W-1:0]  LowW    = W'(LOW_THRESH);
  localparam logic [BW-1:0] BoxLast = BW'(BOX_SIZE - 1);

  typedef enum logic [1:0] {
    StNormal = 2'b00,
    StBaixo  = 2'b01,
    StVazio  = 2'b10,
    StAbast  = 2'b11
  } state_e;

  state_e          estado_q, estado_d;
  logic            gp_q;
  logic [W-1:0]    estoque_q, estoque_d;
  logic [15:0]     total_q, total_d;
  logic [BW-1:0]   box_q, box_d;
  logic            caixa_q, caixa_d;
  logic            erro_q, erro_d;
  logic            cons, add;

  assign cons      = GP & ~gp_q;
  assign add_ready = (estoque_q != CapW) && (estado_q != StNormal);
  assign add       = add_valid & add_ready;

  // Stock update and error flag; a simultaneous consume and add cancel out.
  always_comb begin
    estoque_d = estoque_q;
    erro_d    = erro_q;
    if (add && !cons) begin
      estoque_d = estoque_q + W'(1);
    end else if (cons && !add) begin
      if (estoque_q != '0) begin
        estoque_d = estoque_q - W'(1);
      end else begin
        erro_d = 1'b1;
      end
    end
  end

  always_comb begin
    total_d = total_q;
    box_d   = box_q;
    caixa_d = 1'b0;
    if (cons) begin
      total_d = total_q + 16'd1;
      if (box_q == BoxLast) begin
        box_d   = '0;
        caixa_d = 1'b1;
      end else begin
        box_d = box_q + BW'(1);
      end
    end
  end

  // Transitions look at the next stock value so state and stock move together.
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      StNormal: begin
        if (estoque_d == '0) begin
          estado_d = StVazio;
        end else if (estoque_d <= LowW) begin
          estado_d = StBaixo;
        end
      end
      StBaixo: begin
        if (add) begin
          estado_d = (estoque_d == CapW) ? StNormal : StAbast;
        end else if (estoque_d == '0) begin
          estado_d = StVazio;
        end
      end
      StVazio: begin
        if (add) begin
          estado_d = (estoque_d == CapW) ? StNormal : StAbast;
        end
      end
      StAbast: begin
        if (estoque_d == CapW) begin
          estado_d = StNormal;
        end
      end
      default: estado_d = StNormal;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= StNormal;
      gp_q      <= 1'b0;
      estoque_q <= CapW;
      total_q   <= '0;
      box_q     <= '0;
      caixa_q   <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      gp_q      <= GP;
      estoque_q <= estoque_d;
      total_q   <= total_d;
      box_q     <= box_d;
      caixa_q   <= caixa_d;
      erro_q    <= erro_d;
    end
  end

  assign estoque        = estoque_q;
  assign estado         = estado_q;
  assign total_garrafas = total_q;
  assign caixa_pronta   = caixa_q;
  assign erro_consumo   = erro_q;
  assign RO             = (estoque_q != '0);
  assign req_abast      = (estado_q != StNormal);

endmodule

// File: tb/tb_estoque_rolhas.sv
// Directed bench for estoque_rolhas: vector table for the first bottles, then
// hand-written drain, refill, simultaneous-event, reset, box and wrap sequences.
module tb_estoque_rolhas;

  logic        clk;
  logic        reset;
  logic        GP;
  logic        add_valid;
  logic        add_ready;
  logic        RO;
  logic        req_abast;
  logic [4:0]  estoque;
  logic [1:0]  estado;
  logic [15:0] total_garrafas;
  logic        caixa_pronta;
  logic        erro_consumo;

  int checks = 0;
  int errors = 0;
  int exp_stock, exp_state, exp_total, exp_erro;
  int phase = 0;

  estoque_rolhas dut (
    .clk            (clk),
    .reset          (reset),
    .GP             (GP),
    .add_valid      (add_valid),
    .add_ready      (add_ready),
    .RO             (RO),
    .req_abast      (req_abast),
    .estoque        (estoque),
    .estado         (estado),
    .total_garrafas (total_garrafas),
    .caixa_pronta   (caixa_pronta),
    .erro_consumo   (erro_consumo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic gp;
    logic av;
    int   stock;
    int   total;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int caixa);
    chk({tag, "_estoque"}, int'(estoque), exp_stock);
    chk({tag, "_estado"}, int'(estado), exp_state);
    chk({tag, "_RO"}, int'(RO), (exp_stock != 0) ? 1 : 0);
    chk({tag, "_req"}, int'(req_abast), (exp_state != 0) ? 1 : 0);
    chk({tag, "_ready"}, int'(add_ready), (exp_state != 0 && exp_stock != 20) ? 1 : 0);
    chk({tag, "_total"}, int'(total_garrafas), exp_total);
    chk({tag, "_caixa"}, int'(caixa_pronta), caixa);
    chk({tag, "_erro"}, int'(erro_consumo), exp_erro);
  endtask

  task automatic pulse(input string tag, input int stock, input int st, input int caixa);
    exp_stock = stock;
    exp_state = st;
    exp_total = (exp_total + 1) % 65536;
    GP = 1'b1;
    step();
    chk_all({tag, "_rise"}, caixa);
    GP = 1'b0;
    step();
    chk_all({tag, "_fall"}, 0);
  endtask

  // Bursts of three add_valid cycles separated by two-cycle gaps.
  task automatic refill_to(input int target);
    int guard;
    guard = 0;
    while (exp_stock < target && guard < 60) begin
      add_valid = ((phase % 5) < 3);
      step();
      if (add_valid) begin
        exp_stock++;
        exp_state = (exp_stock == 20) ? 0 : 3;
      end
      phase++;
      guard++;
      chk_all("refill", 0);
    end
    add_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 19, 1};
    vecs[1] = '{1'b1, 1'b0, 19, 1};
    vecs[2] = '{1'b1, 1'b0, 19, 1};
    vecs[3] = '{1'b1, 1'b0, 19, 1};
    vecs[4] = '{1'b1, 1'b0, 19, 1};
    vecs[5] = '{1'b0, 1'b0, 19, 1};
    vecs[6] = '{1'b0, 1'b1, 19, 1};
    vecs[7] = '{1'b1, 1'b1, 18, 2};
    vecs[8] = '{1'b0, 1'b0, 18, 2};

    reset = 1'b0;
    GP = 1'b0;
    add_valid = 1'b0;
    exp_stock = 20;
    exp_state = 0;
    exp_total = 0;
    exp_erro = 0;
    step();
    step();
    chk_all("reset", 0);
    reset = 1'b1;

    // One long GP level, then add_valid in NORMAL must be ignored.
    for (int i = 0; i < 9; i++) begin
      GP = vecs[i].gp;
      add_valid = vecs[i].av;
      step();
      exp_stock = vecs[i].stock;
      exp_total = vecs[i].total;
      chk_all($sformatf("vec%0d", i), 0);
    end
    add_valid = 1'b0;

    for (int k = 1; k <= 13; k++) begin
      pulse("drain", 18 - k, (18 - k <= 5) ? 1 : 0, ((exp_total + 1) % 12 == 0) ? 1 : 0);
    end
    for (int k = 1; k <= 5; k++) begin
      pulse("empty", 5 - k, (5 - k == 0) ? 2 : 1, 0);
    end
    exp_erro = 1;
    pulse("err", 0, 2, 0);
    chk("total_after_err", int'(total_garrafas), 21);

    refill_to(10);
    GP = 1'b1;
    add_valid = 1'b1;
    step();
    exp_total = 22;
    chk_all("simul", 0);
    GP = 1'b0;
    add_valid = 1'b0;
    step();
    chk_all("simul_after", 0);
    pulse("abast_cons", 9, 3, 0);
    refill_to(20);
    chk("refill_done_ready", int'(add_ready), 0);
    chk("refill_done_req", int'(req_abast), 0);

    for (int k = 1; k <= 16; k++) begin
      pulse("drain2", 20 - k, (20 - k <= 5) ? 1 : 0, ((exp_total + 1) % 12 == 0) ? 1 : 0);
    end
    refill_to(7);
    chk("pre_rst_estado", int'(estado), 3);

    #2;
    reset = 1'b0;
    #1;
    exp_stock = 20;
    exp_state = 0;
    exp_total = 0;
    exp_erro = 0;
    chk_all("rst_mid", 0);
    step();
    reset = 1'b1;

    for (int k = 1; k <= 12; k++) begin
      pulse("box", 20 - k, 0, (k == 12) ? 1 : 0);
    end

    dut.total_q <= 16'hFFFE;
    #1;
    exp_total = 65534;
    pulse("pre_wrap", 7, 0, 0);
    pulse("wrap", 6, 0, 0);
    chk("wrap_total", int'(total_garrafas), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
